// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads the sysid slave's ID and build timestamp,
// compares against expected values with bounded retries, and reports pass/fail.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h589E_4B3E,
  parameter bit          CHECK_TS     = 1'b1,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned RETRY_GAP    = 4,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [3:0]  retry_count,
  output logic [2:0]  state_dbg
);

  // Handshake: the sysid slave has no waitrequest; one sysid_read cycle per word,
  // and readdata is taken exactly READ_LATENCY cycles after the strobe cycle.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    WT_ID = 3'd2,
    RD_TS = 3'd3,
    WT_TS = 3'd4,
    CMP   = 3'd5,
    GAP   = 3'd6,
    DONE  = 3'd7
  } state_t;

  localparam bit       LAT0     = (READ_LATENCY == 0);
  localparam logic [2:0] LAT_CAP  = 3'(READ_LATENCY);
  localparam logic [2:0] LAT_WAIT = LAT0 ? 3'd1 : 3'(READ_LATENCY);
  localparam logic [7:0] GAP_LEN  = 8'(RETRY_GAP);
  localparam logic [3:0] MAX_R    = 4'(MAX_RETRIES);

  state_t     state, state_nx;
  logic [2:0] lat_cnt;
  logic [7:0] gap_cnt;
  logic       pending_start;
  logic       match;
  logic       start_check;
  logic       cap_id, cap_ts;

  assign match = (id_value == EXPECTED_ID) && (!CHECK_TS || (ts_value == EXPECTED_TS));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start || pending_start) state_nx = RD_ID;
      RD_ID: state_nx = WT_ID;
      WT_ID: if (lat_cnt == LAT_WAIT) state_nx = RD_TS;
      RD_TS: state_nx = WT_TS;
      WT_TS: if (lat_cnt == LAT_WAIT) state_nx = CMP;
      CMP: begin
        if (match)                    state_nx = DONE;
        else if (retry_count < MAX_R) state_nx = GAP;
        else                          state_nx = DONE;
      end
      GAP:   if (gap_cnt == GAP_LEN) state_nx = RD_ID;
      DONE:  if (start) state_nx = RD_ID;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sysid_read  = (state == RD_ID) || (state == RD_TS);
    // A start pulse in DONE plays the same role as the IDLE launch cycle.
    start_check = ((state == IDLE) && (start || pending_start)) ||
                  ((state == DONE) && start);
    cap_id      = LAT0 ? (state == RD_ID) : ((state == WT_ID) && (lat_cnt == LAT_CAP));
    cap_ts      = LAT0 ? (state == RD_TS) : ((state == WT_TS) && (lat_cnt == LAT_CAP));
    state_dbg   = state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_start <= AUTO_START;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      retry_count   <= 4'd0;
      id_value      <= 32'd0;
      ts_value      <= 32'd0;
      sysid_address <= 1'b0;
      lat_cnt       <= 3'd1;
      gap_cnt       <= 8'd1;
    end else begin
      if (start_check) begin
        pending_start <= 1'b0;
        busy          <= 1'b1;
        done          <= 1'b0;
        pass          <= 1'b0;
        fail          <= 1'b0;
        retry_count   <= 4'd0;
      end

      if ((state == WT_ID) || (state == WT_TS)) lat_cnt <= lat_cnt + 3'd1;
      else                                      lat_cnt <= 3'd1;

      if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
      else              gap_cnt <= 8'd1;

      // Address only moves when a strobe is about to issue, so it holds otherwise.
      if (state_nx == RD_ID)      sysid_address <= 1'b0;
      else if (state_nx == RD_TS) sysid_address <= 1'b1;

      if (cap_id) id_value <= sysid_readdata;
      if (cap_ts) ts_value <= sysid_readdata;

      if (state == CMP) begin
        if (match) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= 1'b1;
        end else if (retry_count < MAX_R) begin
          retry_count <= retry_count + 4'd1;
        end else begin
          busy <= 1'b0;
          done <= 1'b1;
          fail <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: two instances (zero-latency defaults, and a
// latency-3 / ID-only variant) driven by behavioural sysid slaves.
module tb_sysid_boot_checker;

  localparam logic [31:0] A_ID = 32'h0000_0000;
  localparam logic [31:0] A_TS = 32'h589E_4B3E;
  localparam int A_MAX = 3, A_GAP = 4, A_LAT = 0;
  localparam logic [31:0] B_ID = 32'hCAFE_0001;
  localparam logic [31:0] B_TS = 32'h0BAD_F00D;
  localparam int B_MAX = 1, B_GAP = 2, B_LAT = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, rst_b, start_a, start_b;
  logic        addr_a, read_a, busy_a, done_a, pass_a, fail_a;
  logic        addr_b, read_b, busy_b, done_b, pass_b, fail_b;
  logic [31:0] rdata_a, rdata_b, id_a, ts_a, id_b, ts_b;
  logic [3:0]  retry_a, retry_b;
  logic [2:0]  state_dbg_a, state_dbg_b;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] a_id_tab[16], a_ts_tab[16], b_id_tab[16], b_ts_tab[16];
  int a_reads = 0, a_base = 0, b_reads = 0, b_base = 0;
  logic [0:0] obs_a_q[$], obs_b_q[$];
  logic [0:0] exp_q[$];

  sysid_boot_checker #(
    .EXPECTED_ID(A_ID), .EXPECTED_TS(A_TS), .CHECK_TS(1'b1), .READ_LATENCY(A_LAT),
    .MAX_RETRIES(A_MAX), .RETRY_GAP(A_GAP), .AUTO_START(1'b1)
  ) dut_a (
    .clock(clock), .reset(rst_a), .start(start_a),
    .sysid_address(addr_a), .sysid_read(read_a), .sysid_readdata(rdata_a),
    .id_value(id_a), .ts_value(ts_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .fail(fail_a), .retry_count(retry_a), .state_dbg(state_dbg_a)
  );

  sysid_boot_checker #(
    .EXPECTED_ID(B_ID), .EXPECTED_TS(B_TS), .CHECK_TS(1'b0), .READ_LATENCY(B_LAT),
    .MAX_RETRIES(B_MAX), .RETRY_GAP(B_GAP), .AUTO_START(1'b0)
  ) dut_b (
    .clock(clock), .reset(rst_b), .start(start_b),
    .sysid_address(addr_b), .sysid_read(read_b), .sysid_readdata(rdata_b),
    .id_value(id_b), .ts_value(ts_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .fail(fail_b), .retry_count(retry_b), .state_dbg(state_dbg_b)
  );

  // Attempt index within the current check: two strobes per attempt.
  function automatic int tidx(input int reads, input int base);
    int i;
    i = (reads - base) / 2;
    if (i > 15) i = 15;
    if (i < 0)  i = 0;
    return i;
  endfunction

  // Slave A: zero latency, data valid during the strobe cycle, garbage otherwise.
  always_comb begin
    rdata_a = 32'hFFFF_FFFF;
    if (read_a) rdata_a = addr_a ? a_ts_tab[tidx(a_reads, a_base)] : a_id_tab[tidx(a_reads, a_base)];
  end

  always @(posedge clock) begin
    if (read_a) begin
      obs_a_q.push_back(addr_a);
      a_reads <= a_reads + 1;
    end
  end

  // Slave B: data valid only on the third cycle after the strobe.
  logic [2:0]  pv = 3'b000;
  logic [31:0] pd0, pd1, pd2;
  always @(posedge clock) begin
    pv  <= {pv[1:0], read_b};
    pd0 <= read_b ? (addr_b ? b_ts_tab[tidx(b_reads, b_base)] : b_id_tab[tidx(b_reads, b_base)]) : 32'd0;
    pd1 <= pd0;
    pd2 <= pd1;
    if (read_b) begin
      obs_b_q.push_back(addr_b);
      b_reads <= b_reads + 1;
    end
  end
  assign rdata_b = pv[2] ? pd2 : 32'hFFFF_FFFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bad_of(input logic [31:0] good);
    logic [31:0] v;
    v = $urandom;
    if (v == good) v = ~good;
    return v;
  endfunction

  // Reference model: first matching attempt decides pass; each attempt costs two
  // strobe+wait pairs and a compare cycle, with RETRY_GAP idle cycles between.
  function automatic void ref_model(input logic [15:0] ok, input int max_r, input int lat,
                                    input int gap, output logic exp_pass, output int exp_retry,
                                    output int exp_cyc, output int n_att);
    int per;
    per = 2 * (1 + ((lat < 1) ? 1 : lat)) + 1;
    n_att = max_r + 1;
    exp_pass = 1'b0;
    for (int k = 0; k <= max_r; k++) begin
      if (ok[k] && !exp_pass) begin
        n_att = k + 1;
        exp_pass = 1'b1;
      end
    end
    exp_retry = n_att - 1;
    exp_cyc = 1 + n_att * per + (n_att - 1) * gap;
  endfunction

  task automatic drive_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic chk_reset(input bit sel, input string tag);
    if (!sel) begin
      check({tag, ".busy"}, busy_a, 0);   check({tag, ".done"}, done_a, 0);
      check({tag, ".pass"}, pass_a, 0);   check({tag, ".fail"}, fail_a, 0);
      check({tag, ".retry"}, retry_a, 0); check({tag, ".id"}, id_a, 0);
      check({tag, ".ts"}, ts_a, 0);       check({tag, ".read"}, read_a, 0);
      check({tag, ".addr"}, addr_a, 0);
    end else begin
      check({tag, ".busy"}, busy_b, 0);   check({tag, ".done"}, done_b, 0);
      check({tag, ".pass"}, pass_b, 0);   check({tag, ".fail"}, fail_b, 0);
      check({tag, ".retry"}, retry_b, 0); check({tag, ".id"}, id_b, 0);
      check({tag, ".ts"}, ts_b, 0);       check({tag, ".read"}, read_b, 0);
      check({tag, ".addr"}, addr_b, 0);
    end
  endtask

  // Runs one check (auto-started or via a start pulse), optionally poking start
  // while busy at cycle 'poke', then compares everything against the model.
  task automatic run_check(input bit sel, input bit use_start, input int poke, input string tag);
    int cyc = 0;
    int ob, sz, er, ec, na;
    logic got = 1'b0;
    logic viol = 1'b0;
    logic p;
    logic [15:0] ok;
    logic [31:0] wid, wts;
    if (!sel) begin a_base = a_reads; ob = obs_a_q.size(); end
    else      begin b_base = b_reads; ob = obs_b_q.size(); end
    if (use_start) begin @(negedge clock); drive_start(sel, 1'b1); end
    while (!got && cyc < 500) begin
      @(posedge clock); #1;
      cyc++;
      if (use_start && cyc == 1) drive_start(sel, 1'b0);
      if (poke != 0 && cyc == poke) drive_start(sel, 1'b1);
      if (poke != 0 && cyc == poke + 1) drive_start(sel, 1'b0);
      if (!sel) begin
        got = done_a;
        viol = viol | (busy_a & (pass_a | fail_a)) | (pass_a & fail_a);
      end else begin
        got = done_b;
        viol = viol | (busy_b & (pass_b | fail_b)) | (pass_b & fail_b);
      end
    end
    for (int k = 0; k < 16; k++)
      ok[k] = sel ? (b_id_tab[k] == B_ID) : ((a_id_tab[k] == A_ID) && (a_ts_tab[k] == A_TS));
    if (!sel) ref_model(ok, A_MAX, A_LAT, A_GAP, p, er, ec, na);
    else      ref_model(ok, B_MAX, B_LAT, B_GAP, p, er, ec, na);
    wid = sel ? b_id_tab[na - 1] : a_id_tab[na - 1];
    wts = sel ? b_ts_tab[na - 1] : a_ts_tab[na - 1];
    check({tag, ".done"}, got, 1);
    check({tag, ".cycles"}, cyc, ec);
    check({tag, ".excl"}, viol, 0);
    check({tag, ".pass"}, sel ? pass_b : pass_a, p);
    check({tag, ".fail"}, sel ? fail_b : fail_a, !p);
    check({tag, ".retry"}, sel ? retry_b : retry_a, er);
    check({tag, ".id"}, sel ? id_b : id_a, wid);
    check({tag, ".ts"}, sel ? ts_b : ts_a, wts);
    check({tag, ".busy"}, sel ? busy_b : busy_a, 0);
    exp_q.delete();
    for (int i = 0; i < 2 * na; i++) exp_q.push_back(1'(i % 2));
    sz = sel ? obs_b_q.size() : obs_a_q.size();
    check({tag, ".nreads"}, sz - ob, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (ob + i < sz) check({tag, ".raddr"}, sel ? obs_b_q[ob + i] : obs_a_q[ob + i], exp_q[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ob;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a_id_tab[k] = A_ID; a_ts_tab[k] = A_TS;
      b_id_tab[k] = B_ID; b_ts_tab[k] = 32'hDEAD_BEEF;
    end
    repeat (2) @(negedge clock);
    chk_reset(1'b0, "rst_a");
    chk_reset(1'b1, "rst_b");

    // Auto check after reset with a good slave.
    rst_a = 1'b0; rst_b = 1'b0;
    run_check(1'b0, 1'b0, 0, "auto_pass");

    // Timestamp always wrong: all retries used.
    for (int k = 0; k < 16; k++) a_ts_tab[k] = 32'h1234_5678;
    run_check(1'b0, 1'b1, 0, "ts_fail");

    // Bad timestamp on the first two attempts only.
    a_ts_tab[0] = bad_of(A_TS); a_ts_tab[1] = bad_of(A_TS);
    for (int k = 2; k < 16; k++) a_ts_tab[k] = A_TS;
    run_check(1'b0, 1'b1, 0, "pass_on_3rd");

    // Random per-attempt corruption of ID and timestamp.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 16; k++) begin
        a_id_tab[k] = ($urandom_range(0, 2) == 0) ? bad_of(A_ID) : A_ID;
        a_ts_tab[k] = ($urandom_range(0, 2) == 0) ? bad_of(A_TS) : A_TS;
      end
      run_check(1'b0, 1'b1, 0, $sformatf("rand%0d", it));
    end

    // Instance B never starts on its own.
    repeat (20) @(negedge clock);
    check("b_noauto.busy", busy_b, 0);
    check("b_noauto.done", done_b, 0);
    check("b_noauto.reads", obs_b_q.size(), 0);

    // Latency 3, timestamp ignored, garbage outside the valid cycle.
    run_check(1'b1, 1'b1, 0, "b_lat_pass");
    b_id_tab[0] = bad_of(B_ID);
    for (int k = 0; k < 16; k++) b_ts_tab[k] = $urandom;
    run_check(1'b1, 1'b1, 0, "b_retry_pass");
    for (int k = 0; k < 16; k++) b_id_tab[k] = bad_of(B_ID);
    run_check(1'b1, 1'b1, 0, "b_fail");

    // Reset during the timestamp wait, then start while busy.
    for (int k = 0; k < 16; k++) begin a_id_tab[k] = A_ID; a_ts_tab[k] = A_TS; end
    @(negedge clock); rst_a = 1'b1;
    @(negedge clock); rst_a = 1'b0;
    ob = obs_a_q.size();
    a_base = a_reads;
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("midrst.busy_before", busy_a, 1);
    rst_a = 1'b1;
    #1;
    chk_reset(1'b0, "midrst");
    check("midrst.reads", obs_a_q.size() - ob, 2);
    @(negedge clock); rst_a = 1'b0;
    run_check(1'b0, 1'b0, 2, "after_rst");
    ob = obs_a_q.size();
    repeat (12) @(negedge clock);
    check("no_requeue.reads", obs_a_q.size() - ob, 0);
    check("no_requeue.done", done_a, 1);
    check("no_requeue.busy", busy_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
